mem_access_unit: RTL and testbench

Load/store sequencer that sits directly upstream of `data_memory` and drives its `address`, `MemRead`, `MemWrite` and `write_data` ports. It accepts byte-addressed load and store requests of byte, halfword or word size from the execute stage over a valid/ready handshake. It performs read-modify-write for sub-word stores and sign- or zero-extends sub-word loads. It returns one response per request and flags misaligned or illegal accesses without touching memory.

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of data_memory: byte/half/word accesses with
// read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
module mem_access_unit #(
    parameter int W = 32,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N+1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    output logic [W-1:0] resp_rdata,
    output logic         resp_error,
    output logic [N-1:0] mem_address,
    output logic         MemRead,
    output logic         MemWrite,
    output logic [W-1:0] mem_write_data,
    input  logic [W-1:0] mem_read_data
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t       state_reg;
    logic         write_reg;
    logic         unsigned_reg;
    logic [1:0]   size_reg;
    logic [1:0]   lane_reg;
    logic [W-1:0] wdata_reg;

    logic         resp_valid_reg;
    logic         resp_error_reg;
    logic [W-1:0] resp_rdata_reg;
    logic         mem_read_reg;
    logic         mem_write_reg;
    logic [N-1:0] mem_address_reg;
    logic [W-1:0] mem_write_data_reg;

    logic         req_error;
    logic [3:0]   lane_sel;
    logic [W-1:0] wdata_rep;
    logic [W-1:0] merged_word;
    logic [W-1:0] load_ext;
    logic [7:0]   byte_val;
    logic [15:0]  half_val;

    assign req_ready      = (state_reg == IDLE) && rst;
    assign resp_valid     = resp_valid_reg;
    assign resp_error     = resp_error_reg;
    assign resp_rdata     = resp_rdata_reg;
    assign MemRead        = mem_read_reg;
    assign MemWrite       = mem_write_reg;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;

    always_comb begin
        req_error = (req_size == 2'b11)
                 || ((req_size == SIZE_HALF) && req_addr[0])
                 || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    end

    // Store data replicated across lanes so each lane picks its slice directly.
    always_comb begin
        case (size_reg)
            SIZE_BYTE: wdata_rep = {4{wdata_reg[7:0]}};
            SIZE_HALF: wdata_rep = {2{wdata_reg[15:0]}};
            default:   wdata_rep = wdata_reg;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_sel[gi] = (size_reg == SIZE_WORD)
                               || ((size_reg == SIZE_HALF) && (lane_reg[1] == LANE[1]))
                               || ((size_reg == SIZE_BYTE) && (lane_reg == LANE));
            assign merged_word[8*gi +: 8] = lane_sel[gi] ? wdata_rep[8*gi +: 8]
                                                         : mem_read_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_val = 8'(mem_read_data >> {lane_reg, 3'b000});
        half_val = lane_reg[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_reg)
            SIZE_BYTE: load_ext = {{24{~unsigned_reg & byte_val[7]}}, byte_val};
            SIZE_HALF: load_ext = {{16{~unsigned_reg & half_val[15]}}, half_val};
            default:   load_ext = mem_read_data;
        endcase
    end

    // Strobes are registered with the state so MemWrite falls with the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= IDLE;
            write_reg          <= 1'b0;
            unsigned_reg       <= 1'b0;
            size_reg           <= 2'b00;
            lane_reg           <= 2'b00;
            wdata_reg          <= '0;
            resp_valid_reg     <= 1'b0;
            resp_error_reg     <= 1'b0;
            resp_rdata_reg     <= '0;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg       <= req_write;
                        unsigned_reg    <= req_unsigned;
                        size_reg        <= req_size;
                        lane_reg        <= req_addr[1:0];
                        wdata_reg       <= req_wdata;
                        mem_address_reg <= req_addr[N+1:2];
                        if (req_error) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_error_reg <= 1'b1;
                        end else if (req_write && (req_size == SIZE_WORD)) begin
                            state_reg          <= WRITE;
                            mem_write_reg      <= 1'b1;
                            mem_write_data_reg <= req_wdata;
                        end else begin
                            state_reg    <= READ;
                            mem_read_reg <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_read_reg <= 1'b0;
                    if (write_reg) begin
                        state_reg          <= WRITE;
                        mem_write_reg      <= 1'b1;
                        mem_write_data_reg <= merged_word;
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_ext;
                    end
                end
                WRITE: begin
                    mem_write_reg  <= 1'b0;
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                end
                RESP: begin
                    state_reg      <= IDLE;
                    resp_rdata_reg <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data_memory model
// (combinational read, write on the rising edge while MemWrite is high).
module tb_mem_access_unit;

    localparam int W = 32;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [1:0]   req_size = 2'b00;
    logic         req_unsigned = 1'b0;
    logic [N+1:0] req_addr = '0;
    logic [W-1:0] req_wdata = '0;
    logic         resp_valid;
    logic [W-1:0] resp_rdata;
    logic         resp_error;
    logic [N-1:0] mem_address;
    logic         MemRead;
    logic         MemWrite;
    logic [W-1:0] mem_write_data;
    logic [W-1:0] mem_read_data;

    logic [W-1:0] mem [0:(1<<N)-1];
    logic         bd_we = 1'b0;
    logic [N-1:0] bd_addr = '0;
    logic [W-1:0] bd_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address), .MemRead(MemRead),
        .MemWrite(MemWrite), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_address];

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (MemWrite)
            mem[mem_address] <= mem_write_data;
    end

    task automatic poke(input logic [N-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Drives one request at a negedge while ready, returns 1ns into cycle 1.
    task automatic issue(input logic w, input logic [1:0] s, input logic u,
                         input logic [N+1:0] a, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL issue_ready_timeout: req_ready=%b required 1", req_ready);
            failures++;
        end
        $display("req write=%0d size=%0d uns=%0d addr=0x%02h wdata=0x%08h", w, s, u, a, d);
        req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_error, MemRead, MemWrite} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b required 00000",
                     {req_ready, resp_valid, resp_error, MemRead, MemWrite});
            failures++;
        end
        checks++;
        if ({resp_rdata, mem_address, mem_write_data} !== '0) begin
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0",
                     resp_rdata, mem_address, mem_write_data);
            failures++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
            failures++;
        end
    endtask

    task automatic test_word_store_load;
        issue(1'b1, 2'b10, 1'b0, 7'h0C, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({MemWrite, MemRead, mem_address, mem_write_data} !== {2'b10, 5'd3, 32'hDEADBEEF}) begin
            $display("FAIL word_store_c1: we=%b re=%b addr=%0d data=%h required we=1 re=0 addr=3 data=deadbeef",
                     MemWrite, MemRead, mem_address, mem_write_data);
            failures++;
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'h0} || mem[3] !== 32'hDEADBEEF) begin
            $display("FAIL word_store_resp: v=%b e=%b rdata=%h mem=%h required v=1 e=0 rdata=0 mem=deadbeef",
                     resp_valid, resp_error, resp_rdata, mem[3]);
            failures++;
        end
        issue(1'b0, 2'b10, 1'b0, 7'h0C, 32'h0);
        @(negedge clk);
        checks++;
        if ({MemRead, MemWrite, resp_valid} !== 3'b100) begin
            $display("FAIL word_load_c1: re=%b we=%b v=%b required 1 0 0", MemRead, MemWrite, resp_valid);
            failures++;
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            $display("FAIL word_load_resp: v=%b e=%b rdata=%h required v=1 e=0 rdata=deadbeef",
                     resp_valid, resp_error, resp_rdata);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL word_load_pulse: resp_valid=%b required 0 in cycle 3", resp_valid);
            failures++;
        end
    endtask

    task automatic test_subword_loads;
        logic [1:0]   sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic         un  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [6:0]   ad  [5] = '{7'h0D, 7'h0D, 7'h0E, 7'h0C, 7'h7F};
        logic [31:0]  ex  [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB, 32'h000000C3};
        logic [N-1:0] wa  [5] = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd31};
        poke(5'd3, 32'h8899AABB);
        poke(5'd31, 32'hC3000000);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0);
            @(negedge clk);
            checks++;
            if ({MemRead, mem_address} !== {1'b1, wa[i]}) begin
                $display("FAIL subload_addr[%0d]: re=%b addr=%0d required re=1 addr=%0d",
                         i, MemRead, mem_address, wa[i]);
                failures++;
            end
            @(negedge clk);
            checks++;
            if ({resp_valid, resp_error, resp_rdata} !== {2'b10, ex[i]}) begin
                $display("FAIL subload_data[%0d]: v=%b e=%b rdata=%h required v=1 e=0 rdata=%h",
                         i, resp_valid, resp_error, resp_rdata, ex[i]);
                failures++;
            end
        end
    endtask

    task automatic test_subword_stores;
        poke(5'd3, 32'h8899AABB);
        issue(1'b1, 2'b00, 1'b0, 7'h0E, 32'hFFFFFF55);
        @(negedge clk);
        checks++;
        if ({MemRead, MemWrite, resp_valid} !== 3'b100) begin
            $display("FAIL substore_byte_c1: re=%b we=%b v=%b required 1 0 0", MemRead, MemWrite, resp_valid);
            failures++;
        end
        @(negedge clk);
        checks++;
        if ({MemRead, MemWrite, mem_address, mem_write_data} !== {2'b01, 5'd3, 32'h8855AABB}) begin
            $display("FAIL substore_byte_c2: re=%b we=%b addr=%0d data=%h required re=0 we=1 addr=3 data=8855aabb",
                     MemRead, MemWrite, mem_address, mem_write_data);
            failures++;
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'h0} || mem[3] !== 32'h8855AABB) begin
            $display("FAIL substore_byte_c3: v=%b e=%b rdata=%h mem=%h required v=1 e=0 rdata=0 mem=8855aabb",
                     resp_valid, resp_error, resp_rdata, mem[3]);
            failures++;
        end
        issue(1'b1, 2'b01, 1'b0, 7'h0C, 32'hABCD1234);
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || mem_write_data !== 32'h88551234) begin
            $display("FAIL substore_half_c2: v=%b data=%h required v=0 data=88551234", resp_valid, mem_write_data);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || mem[3] !== 32'h88551234) begin
            $display("FAIL substore_half_c3: v=%b mem=%h required v=1 mem=88551234", resp_valid, mem[3]);
            failures++;
        end
    endtask

    task automatic test_errors;
        logic       wr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] sz [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
        logic [6:0] ad [4] = '{7'h0D, 7'h0E, 7'h00, 7'h00};
        poke(5'd3, 32'h11223344);
        poke(5'd0, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            issue(wr[i], sz[i], 1'b0, ad[i], 32'h5A5A5A5A);
            @(negedge clk);
            checks++;
            if ({resp_valid, resp_error, MemRead, MemWrite, resp_rdata} !== {4'b1100, 32'h0}) begin
                $display("FAIL error_resp[%0d]: v=%b e=%b re=%b we=%b rdata=%h required v=1 e=1 re=0 we=0 rdata=0",
                         i, resp_valid, resp_error, MemRead, MemWrite, resp_rdata);
                failures++;
            end
            @(negedge clk);
            checks++;
            if ({resp_valid, MemRead, MemWrite} !== 3'b000) begin
                $display("FAIL error_after[%0d]: v=%b re=%b we=%b required 0 0 0",
                         i, resp_valid, MemRead, MemWrite);
                failures++;
            end
        end
        checks++;
        if (mem[3] !== 32'h11223344 || mem[0] !== 32'hCAFEF00D) begin
            $display("FAIL error_mem: mem3=%h mem0=%h required 11223344 cafef00d", mem[3], mem[0]);
            failures++;
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        poke(5'd4, 32'h01020304);
        poke(5'd5, 32'hA0B0C0D0);
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        $display("req back_to_back load addr=0x10 then addr=0x14");
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 7'h10;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_addr = 7'h14;
        @(negedge clk);
        checks++;
        if ({req_ready, MemRead, mem_address} !== {2'b01, 5'd4}) begin
            $display("FAIL b2b_c1: ready=%b re=%b addr=%0d required ready=0 re=1 addr=4",
                     req_ready, MemRead, mem_address);
            failures++;
        end
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_rdata} !== {2'b01, 32'h01020304}) begin
            $display("FAIL b2b_c2: ready=%b v=%b rdata=%h required ready=0 v=1 rdata=01020304",
                     req_ready, resp_valid, resp_rdata);
            failures++;
        end
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            $display("FAIL b2b_c3: ready=%b v=%b required ready=1 v=0", req_ready, resp_valid);
            failures++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({resp_valid, MemRead, mem_address} !== {2'b01, 5'd5}) begin
            $display("FAIL b2b_second_c1: v=%b re=%b addr=%0d required v=0 re=1 addr=5",
                     resp_valid, MemRead, mem_address);
            failures++;
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_rdata} !== {1'b1, 32'hA0B0C0D0}) begin
            $display("FAIL b2b_second_c2: v=%b rdata=%h required v=1 rdata=a0b0c0d0", resp_valid, resp_rdata);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL b2b_second_pulse: v=%b required 0", resp_valid);
            failures++;
        end
    endtask

    task automatic test_reset_mid_store;
        poke(5'd6, 32'h13579BDF);
        issue(1'b1, 2'b00, 1'b0, 7'h18, 32'h000000EE);
        repeat (2) @(negedge clk);
        checks++;
        if (MemWrite !== 1'b1) begin
            $display("FAIL rst_mid_write_phase: MemWrite=%b required 1", MemWrite);
            failures++;
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            $display("FAIL rst_mid_async_drop: MemWrite=%b required 0", MemWrite);
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem[6] !== 32'h13579BDF) begin
            $display("FAIL rst_mid_mem: got %h required 13579bdf", mem[6]);
            failures++;
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({req_ready, resp_valid, resp_error, MemRead, MemWrite, resp_rdata, mem_address, mem_write_data} !== '0) begin
                $display("FAIL rst_mid_outputs: ready=%b v=%b e=%b re=%b we=%b rdata=%h addr=%h wdata=%h required all 0",
                         req_ready, resp_valid, resp_error, MemRead, MemWrite, resp_rdata, mem_address, mem_write_data);
                failures++;
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            $display("FAIL rst_mid_release: ready=%b v=%b required ready=1 v=0", req_ready, resp_valid);
            failures++;
        end
        issue(1'b0, 2'b10, 1'b0, 7'h18, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'h13579BDF}) begin
            $display("FAIL rst_mid_reload: v=%b e=%b rdata=%h required v=1 e=0 rdata=13579bdf",
                     resp_valid, resp_error, resp_rdata);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_loads();
        test_subword_stores();
        test_errors();
        test_back_to_back();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
